// File: rtl/color_classifier.sv
// Averages windows of RGB samples, classifies each window average into a cube
// colour, and publishes a colour once enough consecutive windows agree.
module color_classifier #(
    parameter int unsigned      WIDTH          = 8,
    parameter int unsigned      SAMPLE_SHIFT   = 2,
    parameter int unsigned      STABLE_WINDOWS = 2,
    parameter logic [WIDTH-1:0] WHITE_MIN      = 'hA0,
    parameter logic [WIDTH-1:0] WHITE_SPREAD   = 'h30,
    parameter logic [WIDTH-1:0] Y_DELTA        = 'h30,
    parameter logic [WIDTH-1:0] O_DELTA        = 'h90,
    parameter logic [WIDTH-1:0] DARK_MAX       = 'h20
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [WIDTH-1:0] red,
    input  logic [WIDTH-1:0] green,
    input  logic [WIDTH-1:0] blue,
    output logic [2:0]       color,
    output logic             color_valid,
    output logic             busy
);

    // state    | meaning
    // ACCUM    | accepting samples into the window accumulators
    // CLASSIFY | window complete; register the class of the averages
    // DECIDE   | update stability history, publish colour, restart window

    localparam int unsigned ACC_W   = WIDTH + SAMPLE_SHIFT;
    localparam int unsigned CNT_W   = SAMPLE_SHIFT + 1;
    localparam int unsigned SAMPLES = 1 << SAMPLE_SHIFT;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES - 1);
    localparam logic [3:0]       STABLE_TC   = 4'(STABLE_WINDOWS);

    localparam logic [2:0] C_W    = 3'd0;
    localparam logic [2:0] C_O    = 3'd1;
    localparam logic [2:0] C_G    = 3'd2;
    localparam logic [2:0] C_R    = 3'd3;
    localparam logic [2:0] C_B    = 3'd4;
    localparam logic [2:0] C_Y    = 3'd5;
    localparam logic [2:0] C_NONE = 3'd6;

    typedef enum logic [1:0] {
        ACCUM    = 2'd0,
        CLASSIFY = 2'd1,
        DECIDE   = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_g;
    logic [ACC_W-1:0] acc_b;
    logic [CNT_W-1:0] count;
    logic [2:0]       raw_class;
    logic [2:0]       last_raw;
    logic [3:0]       stable_cnt;
    logic [3:0]       stable_next;
    logic [2:0]       window_class;

    function automatic logic [2:0] classify(input logic [WIDTH-1:0] r,
                                            input logic [WIDTH-1:0] g,
                                            input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] mx;
        logic [WIDTH-1:0] mn;
        logic [2:0]       cls;
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        mn = r;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        if (mx < DARK_MAX)
            cls = C_NONE;
        else if (mn >= WHITE_MIN && (mx - mn) <= WHITE_SPREAD)
            cls = C_W;
        else if (r >= g && r >= b) begin
            if ((r - g) <= Y_DELTA)
                cls = C_Y;
            else if ((r - g) <= O_DELTA)
                cls = C_O;
            else
                cls = C_R;
        end
        else if (g >= b)
            cls = C_G;
        else
            cls = C_B;
        return cls;
    endfunction

    // The upper WIDTH bits of each accumulator are the truncated average.
    assign window_class = classify(acc_r[ACC_W-1:SAMPLE_SHIFT],
                                   acc_g[ACC_W-1:SAMPLE_SHIFT],
                                   acc_b[ACC_W-1:SAMPLE_SHIFT]);

    always_comb begin
        stable_next = 4'd1;
        if (raw_class == last_raw)
            stable_next = (stable_cnt >= STABLE_TC) ? STABLE_TC : stable_cnt + 4'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ACCUM;
            acc_r        <= '0;
            acc_g        <= '0;
            acc_b        <= '0;
            count        <= '0;
            raw_class    <= C_NONE;
            last_raw     <= C_NONE;
            stable_cnt   <= 4'd0;
            color        <= C_NONE;
            color_valid  <= 1'b0;
            sample_ready <= 1'b1;
            busy         <= 1'b0;
        end
        else if (clear) begin
            // Colour is deliberately held; only the history is flushed.
            state        <= ACCUM;
            acc_r        <= '0;
            acc_g        <= '0;
            acc_b        <= '0;
            count        <= '0;
            last_raw     <= C_NONE;
            stable_cnt   <= 4'd0;
            color_valid  <= 1'b0;
            sample_ready <= 1'b1;
            busy         <= 1'b0;
        end
        else begin
            color_valid <= 1'b0;
            case (state)
                ACCUM: begin
                    if (sample_valid && sample_ready) begin
                        acc_r <= acc_r + ACC_W'(red);
                        acc_g <= acc_g + ACC_W'(green);
                        acc_b <= acc_b + ACC_W'(blue);
                        count <= count + CNT_W'(1);
                        busy  <= 1'b1;
                        if (count == LAST_SAMPLE) begin
                            state        <= CLASSIFY;
                            sample_ready <= 1'b0;
                        end
                    end
                end
                CLASSIFY: begin
                    raw_class <= window_class;
                    state     <= DECIDE;
                end
                DECIDE: begin
                    last_raw   <= raw_class;
                    stable_cnt <= stable_next;
                    if (stable_next >= STABLE_TC && raw_class != color) begin
                        color       <= raw_class;
                        color_valid <= 1'b1;
                    end
                    acc_r        <= '0;
                    acc_g        <= '0;
                    acc_b        <= '0;
                    count        <= '0;
                    state        <= ACCUM;
                    sample_ready <= 1'b1;
                    busy         <= 1'b0;
                end
                default: begin
                    state        <= ACCUM;
                    sample_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
